// File: rtl/seg_conv_pkg.sv
// Shared constants for the seconds-to-calendar converter: stage divisors,
// stage count and controller state encoding.
package seg_conv_pkg;

    localparam int STAGES = 5;

    localparam logic [31:0] DIV_ANO  = 32'd31536000;
    localparam logic [31:0] DIV_MES  = 32'd2592000;
    localparam logic [31:0] DIV_DIA  = 32'd86400;
    localparam logic [31:0] DIV_HORA = 32'd3600;
    localparam logic [31:0] DIV_MIN  = 32'd60;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t IDLE  = 2'd0;
    localparam fsm_state_t ISSUE = 2'd1;
    localparam fsm_state_t WAIT  = 2'd2;
    localparam fsm_state_t DONE  = 2'd3;

    function automatic logic [31:0] stage_divisor(input logic [2:0] stage);
        logic [31:0] d;
        case (stage)
            3'd0:    d = DIV_ANO;
            3'd1:    d = DIV_MES;
            3'd2:    d = DIV_DIA;
            3'd3:    d = DIV_HORA;
            default: d = DIV_MIN;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_conv_seq_div.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// The first bit is resolved on the edge that latches the operands.
module div_seq #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_done,
    output logic [W-1:0] o_quotient,
    output logic [W-1:0] o_remainder
);

    localparam int CW = $clog2(W) + 1;

    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_dsr;
    logic [CW-1:0] r_cnt;
    logic          r_active;
    logic          r_done;

    logic [W-1:0]  w_rem_in;
    logic [W-1:0]  w_quo_in;
    logic [W-1:0]  w_dsr;
    logic [W:0]    w_trial;
    logic [W:0]    w_diff;
    logic          w_fits;
    logic [W-1:0]  w_rem_next;
    logic [W-1:0]  w_quo_next;

    // One restoring step; on start the step operates on the fresh operands.
    always_comb begin
        if (i_start) begin
            w_rem_in = '0;
            w_quo_in = i_dividend;
            w_dsr    = i_divisor;
        end else begin
            w_rem_in = r_rem;
            w_quo_in = r_quo;
            w_dsr    = r_dsr;
        end
        w_trial    = {w_rem_in, w_quo_in[W-1]};
        w_diff     = w_trial - {1'b0, w_dsr};
        w_fits     = (w_trial >= {1'b0, w_dsr});
        w_rem_next = w_fits ? w_diff[W-1:0] : w_trial[W-1:0];
        w_quo_next = {w_quo_in[W-2:0], w_fits};
    end

    // Operand latch, iteration counter and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_dsr    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_dsr    <= i_divisor;
                r_quo    <= w_quo_next;
                r_rem    <= w_rem_next;
                r_cnt    <= CW'(W - 1);
                r_active <= 1'b1;
            end else if (r_active) begin
                r_quo <= w_quo_next;
                r_rem <= w_rem_next;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign o_done      = r_done;
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/seg_conv_seq.sv
// Converts a seconds count into years/months/days/hours/minutes/seconds by
// sequencing one shared divider through five chained divisor stages.
module seg_conv_seq
    import seg_conv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] in_seg,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] anos,
    output logic [W-1:0] mes,
    output logic [W-1:0] dias,
    output logic [W-1:0] horas,
    output logic [W-1:0] minutos,
    output logic [W-1:0] segundos
);

    fsm_state_t   r_state;
    logic [2:0]   r_stage;
    logic [W-1:0] r_dvd;
    logic [W-1:0] r_q [STAGES];
    logic         r_busy;
    logic         r_done;
    logic [W-1:0] r_anos, r_mes, r_dias, r_horas, r_minutos, r_segundos;

    logic         w_div_start;
    logic         w_div_done;
    logic [W-1:0] w_divisor;
    logic [W-1:0] w_quo;
    logic [W-1:0] w_rem;

    assign w_div_start = (r_state == ISSUE);
    assign w_divisor   = W'(stage_divisor(r_stage));

    div_seq #(.W(W)) u_div (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_dividend  (r_dvd),
        .i_divisor   (w_divisor),
        .o_done      (w_div_done),
        .o_quotient  (w_quo),
        .o_remainder (w_rem)
    );

    // Stage sequencing; results are published together only when leaving DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_stage    <= 3'd0;
            r_dvd      <= '0;
            for (int i = 0; i < STAGES; i++) r_q[i] <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_anos     <= '0;
            r_mes      <= '0;
            r_dias     <= '0;
            r_horas    <= '0;
            r_minutos  <= '0;
            r_segundos <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dvd   <= in_seg;
                        r_stage <= 3'd0;
                        r_busy  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    if (w_div_done) begin
                        r_q[r_stage] <= w_quo;
                        r_dvd        <= w_rem;
                        if (r_stage < 3'(STAGES - 1)) begin
                            r_stage <= r_stage + 3'd1;
                            r_state <= ISSUE;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_anos     <= r_q[0];
                    r_mes      <= r_q[1];
                    r_dias     <= r_q[2];
                    r_horas    <= r_q[3];
                    r_minutos  <= r_q[4];
                    r_segundos <= r_dvd;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign anos     = r_anos;
    assign mes      = r_mes;
    assign dias     = r_dias;
    assign horas    = r_horas;
    assign minutos  = r_minutos;
    assign segundos = r_segundos;

endmodule

// File: tb/tb_seg_conv_seq.sv
// Self-checking bench for seg_conv_seq plus a standalone check of div_seq,
// using an arithmetic reference model and randomized values.
module tb_seg_conv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in_seg;
    logic        busy, done;
    logic [31:0] anos, mes, dias, horas, minutos, segundos;

    logic        d_start;
    logic [31:0] d_a, d_b;
    logic        d_done;
    logic [31:0] d_q, d_r;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] e_v [6];

    always #5 clk = ~clk;

    seg_conv_seq #(.W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .in_seg(in_seg),
        .busy(busy), .done(done), .anos(anos), .mes(mes), .dias(dias),
        .horas(horas), .minutos(minutos), .segundos(segundos)
    );

    div_seq #(.W(32)) u_div_alone (
        .clk(clk), .rst(rst), .i_start(d_start), .i_dividend(d_a),
        .i_divisor(d_b), .o_done(d_done), .o_quotient(d_q), .o_remainder(d_r)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Calendar decomposition: 365-day years, 30-day months.
    task automatic ref_model(input logic [31:0] x);
        longint unsigned r;
        r = x;
        e_v[0] = 32'(r / 64'd31536000); r = r % 64'd31536000;
        e_v[1] = 32'(r / 64'd2592000);  r = r % 64'd2592000;
        e_v[2] = 32'(r / 64'd86400);    r = r % 64'd86400;
        e_v[3] = 32'(r / 64'd3600);     r = r % 64'd3600;
        e_v[4] = 32'(r / 64'd60);       r = r % 64'd60;
        e_v[5] = 32'(r);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".anos"},     anos,     e_v[0]);
        chk({tag, ".mes"},      mes,      e_v[1]);
        chk({tag, ".dias"},     dias,     e_v[2]);
        chk({tag, ".horas"},    horas,    e_v[3]);
        chk({tag, ".minutos"},  minutos,  e_v[4]);
        chk({tag, ".segundos"}, segundos, e_v[5]);
    endtask

    // One conversion; k counts edges after the accepting edge.
    task automatic run_conv(input logic [31:0] v, input string tag);
        int lat = 0;
        int nbusy = 0;
        @(negedge clk);
        in_seg = v;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".busy_first"}, busy, 1);
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                chk({tag, ".busy_at_done"}, busy, 0);
                break;
            end
            if (busy) nbusy++;
        end
        chk({tag, ".latency"}, lat, 166);
        chk({tag, ".busy_cycles"}, nbusy, 165);
        ref_model(v);
        check_outputs(tag);
    endtask

    initial begin
        int ndone, lat, d1, d2, glitch;
        rst = 1'b1; start = 1'b0; in_seg = 32'd0;
        d_start = 1'b0; d_a = 32'd0; d_b = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        e_v = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        check_outputs("rst");
        @(negedge clk); rst = 1'b0;

        run_conv(32'd0,          "zero");
        run_conv(32'd3661,       "t3661");
        run_conv(32'd34218061,   "ones");
        run_conv(32'hFFFF_FFFF,  "max");
        run_conv(32'd31535999,   "yr_minus1");
        run_conv(32'd31536000,   "yr_exact");
        run_conv(32'd100,        "prev100");

        // Start while busy and in_seg changes mid-flight must not disturb the run.
        ndone = 0; lat = 0; glitch = 0;
        @(negedge clk); in_seg = 32'd59; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (k == 10) begin start = 1'b1; in_seg = 32'd3661; end
            if (k == 11) start = 1'b0;
            if (k == 50) in_seg = 32'd12345;
            if (done) begin ndone++; if (lat == 0) lat = k; end
            else if (lat == 0 && (minutos != 32'd1 || segundos != 32'd40)) glitch++;
        end
        chk("inflight.ndone", ndone, 1);
        chk("inflight.latency", lat, 166);
        chk("inflight.glitch", glitch, 0);
        ref_model(32'd59);
        check_outputs("inflight");

        // Start held high through DONE: accepted only in the done cycle.
        d1 = 0; d2 = 0;
        @(negedge clk); in_seg = 32'd7777; start = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 500; k++) begin
            @(posedge clk); #1;
            if (k == 1) in_seg = 32'd98765432;
            if (k == d1 + 1 && d1 != 0) start = 1'b0;
            if (done) begin
                if (d1 == 0) begin
                    d1 = k;
                    ref_model(32'd7777);
                    check_outputs("b2b.first");
                end else begin
                    d2 = k;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b.first_lat", d1, 166);
        chk("b2b.gap", d2 - d1, 167);
        ref_model(32'd98765432);
        check_outputs("b2b.second");

        // Reset mid-conversion aborts and clears immediately.
        ndone = 0;
        @(negedge clk); in_seg = 32'd3661; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        rst = 1'b1; #1;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        e_v = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        check_outputs("abort");
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("abort.no_done", ndone, 0);
        run_conv(32'd60, "after_abort");

        for (int i = 0; i < 15; i++) begin
            logic [31:0] v;
            v = $urandom;
            if (i % 3 == 0) v = v % 32'd100000;
            run_conv(v, $sformatf("rnd%0d", i));
        end

        // Standalone divider: quotient, remainder and 32-cycle latency.
        for (int i = 0; i < 8; i++) begin
            int dl = 0;
            @(negedge clk);
            d_a = $urandom;
            d_b = (i < 4) ? $urandom_range(1, 100000) : $urandom | 32'd1;
            d_start = 1'b1;
            @(posedge clk); #1; d_start = 1'b0;
            for (int k = 1; k <= 100; k++) begin
                @(posedge clk); #1;
                if (d_done) begin dl = k + 1; break; end
            end
            chk($sformatf("div%0d.lat", i), dl, 32);
            chk($sformatf("div%0d.q", i), d_q, d_a / d_b);
            chk($sformatf("div%0d.r", i), d_r, d_a % d_b);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
